// File: rtl/arbitro_rr_nxm.sv
// -----------------------------------------------------------------------------
// arbitro_rr_nxm
//
// Routes words from N_IN first-word-fall-through input FIFOs to N_OUT output
// FIFOs. The destination of each word is taken from its top DEST_W bits.
// At most one input is granted per cycle. The grant is either fixed priority
// (lowest index wins) or round-robin starting at rr_ptr. An input is skipped
// while the output FIFO its head word targets reports almost_full, so a
// blocked destination does not stall traffic to the other destinations.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high
//   enable            0 = issue no new grants; state is held
//   data_in_arb       head words of the input FIFOs, word i at [i*WORD_SIZE +: WORD_SIZE]
//   fifo_empty        per-input empty flags
//   fifos_almost_full per-output almost-full flags
//   pop               combinational one-hot pop, asserted in the grant cycle
//   data_out_arb      registered granted word
//   push              registered one-hot push to the destination FIFO
//   grant_idx         registered index of the input behind the current push
// -----------------------------------------------------------------------------
module arbitro_rr_nxm #(
    parameter int WORD_SIZE = 12,
    parameter int N_IN      = 4,
    parameter int N_OUT     = 4,
    parameter int RR_MODE   = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         enable,
    input  logic [N_IN*WORD_SIZE-1:0]                    data_in_arb,
    input  logic [N_IN-1:0]                              fifo_empty,
    input  logic [N_OUT-1:0]                             fifos_almost_full,
    output logic [N_IN-1:0]                              pop,
    output logic [WORD_SIZE-1:0]                         data_out_arb,
    output logic [N_OUT-1:0]                             push,
    output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0]   grant_idx
);

    localparam int DEST_W = $clog2(N_OUT);
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [DEST_W-1:0]    dest_of [N_IN];
    logic [N_IN-1:0]      eligible;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_sel;
    logic [WORD_SIZE-1:0] grant_word;
    logic [DEST_W-1:0]    grant_dest;
    logic [N_OUT-1:0]     grant_onehot;
    logic [IDX_W-1:0]     rr_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [N_OUT-1:0]     push_q;

    // Destination field of each head word.
    for (genvar i = 0; i < N_IN; i++) begin : g_dest
        assign dest_of[i] = data_in_arb[i*WORD_SIZE + WORD_SIZE-1 -: DEST_W];
    end

    // almost_full is sampled in the grant cycle itself; the egress threshold
    // leaves room for the one word that is still in the output register.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop so that no path leaves it unassigned and infers a latch.
        eligible = '0;
        for (int i = 0; i < N_IN; i++) begin
            eligible[i] = !fifo_empty[i] && !fifos_almost_full[dest_of[i]]
                          && enable && !reset;
        end
    end

    // Scan the inputs starting at rr_ptr (round-robin) or at 0 (fixed
    // priority); the first eligible candidate wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_sel   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < N_IN; k++) begin
            cand     = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % N_IN) : k;
            cand_idx = IDX_W'(cand);
            if (!grant_valid && eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_sel   = cand_idx;
            end
        end
    end

    assign grant_word   = data_in_arb[int'(grant_sel)*WORD_SIZE +: WORD_SIZE];
    assign grant_dest   = grant_word[WORD_SIZE-1 -: DEST_W];
    assign grant_onehot = N_OUT'(1) << grant_dest;
    assign rr_next      = IDX_W'((int'(grant_sel) + 1) % N_IN);

    // grant_valid already implies reset=0, so pop is low throughout reset.
    always_comb begin
        pop = '0;
        if (grant_valid) begin
            pop[grant_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of its inputs.
        if (reset) begin
            // NOTE: only the control path needs a reset for correctness; the
            // data register is cleared as well so the bus reads 0 after reset.
            data_out_arb <= '0;
            push_q       <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
        end else begin
            push_q <= grant_valid ? grant_onehot : '0;
            if (grant_valid) begin
                data_out_arb <= grant_word;
                grant_idx    <= grant_sel;
                rr_ptr       <= rr_next;
            end
        end
    end

    // A reset raised while a word sits in the output register discards it:
    // the push is masked during the reset cycle rather than delivered.
    assign push = push_q & {N_OUT{~reset}};

endmodule
